// File: rtl/cpm_fifo_sched.sv
// Shares one combinational-read CPM FIFO among NUM_REQ writers (round-robin)
// and drains it downstream in fixed-length bursts.
module cpm_fifo_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          Reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic                          fifo_pop,
    output logic                          fifo_clr,
    input  logic [DATA_WIDTH-1:0]         fifo_rdata,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    input  logic [ADDR_WIDTH:0]           fifo_count,
    input  logic                          cfg_en,
    input  logic [ADDR_WIDTH:0]           cfg_burst,
    input  logic                          out_rdy,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic                          burst_done,
    output logic [CNT_WIDTH-1:0]          burst_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   beat_cnt_q, beat_cnt_d;
    logic                  burst_done_q, burst_done_d;
    logic [CNT_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;

    logic [DATA_WIDTH-1:0] slot [NUM_REQ];
    logic [PTR_W-1:0]      win;
    logic                  found;
    logic [ADDR_WIDTH:0]   eff_len;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        assign slot[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        logic [PTR_W:0] sum;
        sum   = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            if (!found && req[sum[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = sum[PTR_W-1:0];
            end
        end
        if (Reset || fifo_full)
            found = 1'b0;
    end

    always_comb begin
        gnt        = '0;
        fifo_wdata = '0;
        rr_ptr_d   = rr_ptr_q;
        if (found) begin
            gnt[win]   = 1'b1;
            fifo_wdata = slot[win];
            rr_ptr_d   = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
        end
    end

    assign fifo_push = found;
    assign fifo_clr  = Reset;

    assign eff_len   = (cfg_burst > DEPTH_L) ? DEPTH_L : cfg_burst;
    assign busy      = (state_q == ST_BURST);
    assign out_valid = busy && !fifo_empty;
    assign fifo_pop  = out_valid && out_rdy && !Reset;
    assign out_last  = out_valid && (beat_cnt_q == (ADDR_WIDTH+1)'(1));
    assign out_data  = fifo_rdata;
    assign burst_done = burst_done_q;
    assign burst_cnt  = burst_cnt_q;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        burst_done_d = 1'b0;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Config is captured only here; mid-burst changes have no effect.
                if (cfg_en && (eff_len != '0) && (fifo_count >= eff_len)) begin
                    state_d    = ST_BURST;
                    beat_cnt_d = eff_len;
                end
            end
            ST_BURST: begin
                if (fifo_pop) begin
                    beat_cnt_d = beat_cnt_q - 1'b1;
                    if (beat_cnt_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d      = ST_IDLE;
                        burst_done_d = 1'b1;
                        burst_cnt_d  = burst_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Synchronous clear aborts any burst without a done pulse.
        if (Reset) begin
            state_d      = ST_IDLE;
            beat_cnt_d   = '0;
            burst_done_d = 1'b0;
            burst_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            burst_done_q <= 1'b0;
            burst_cnt_q  <= '0;
        end else begin
            rr_ptr_q     <= Reset ? '0 : rr_ptr_d;
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_done_q <= burst_done_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_cpm_fifo_sched.sv
// Scoreboard bench: behavioural FIFO + reference model of the scheduler rules;
// a separate monitor pops expected words whenever the DUT pops the FIFO.
module tb_cpm_fifo_sched;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n, Reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            fifo_push, fifo_pop, fifo_clr;
    logic [DW-1:0]   fifo_wdata, fifo_rdata;
    logic            fifo_full, fifo_empty;
    logic [AW:0]     fifo_count;
    logic            cfg_en;
    logic [AW:0]     cfg_burst;
    logic            out_rdy, out_valid, out_last, busy, burst_done;
    logic [DW-1:0]   out_data;
    logic [15:0]     burst_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpm_fifo_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .Reset(Reset), .req(req), .req_data(req_data),
        .gnt(gnt), .fifo_push(fifo_push), .fifo_wdata(fifo_wdata), .fifo_pop(fifo_pop),
        .fifo_clr(fifo_clr), .fifo_rdata(fifo_rdata), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .cfg_en(cfg_en),
        .cfg_burst(cfg_burst), .out_rdy(out_rdy), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .busy(busy),
        .burst_done(burst_done), .burst_cnt(burst_cnt)
    );

    // Behavioural CPM FIFO with combinational read port.
    logic [DW-1:0] fmem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   fcnt;
    assign fifo_full  = (fcnt == 5'(DEPTH));
    assign fifo_empty = (fcnt == 0);
    assign fifo_count = fcnt;
    assign fifo_rdata = fifo_empty ? '0 : fmem[rp];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || fifo_clr) begin
            wp <= '0; rp <= '0; fcnt <= '0;
        end else begin
            if (fifo_push && !fifo_full) begin
                fmem[wp] <= fifo_wdata;
                wp <= wp + 1'b1;
            end
            if (fifo_pop && !fifo_empty) rp <= rp + 1'b1;
            fcnt <= fcnt + 5'(fifo_push && !fifo_full) - 5'(fifo_pop && !fifo_empty);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    int            m_ptr, m_beats, m_cnt;
    bit            m_busy, m_done;
    logic [DW-1:0] exp_q [$];
    logic [N-1:0]  g_seen;

    always @(negedge clk) begin : model
        int w, eff;
        logic [N-1:0]  e_gnt;
        logic [DW-1:0] e_wd;
        bit e_valid, e_pop, e_last;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", burst_done, 0);
            chk("rst_cnt", burst_cnt, 0);
            chk("rst_gnt", gnt, 0);
            m_ptr = 0; m_beats = 0; m_cnt = 0; m_busy = 0; m_done = 0;
            exp_q.delete();
            g_seen = '0;
        end else begin
            w = -1;
            if (!Reset && !fifo_full)
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            e_gnt = '0;
            e_wd  = '0;
            if (w >= 0) begin
                e_gnt[w] = 1'b1;
                e_wd = req_data[w*DW +: DW];
            end
            e_valid = m_busy && !fifo_empty;
            e_pop   = e_valid && out_rdy && !Reset;
            e_last  = e_valid && (m_beats == 1);
            chk("gnt", gnt, e_gnt);
            chk("fifo_push", fifo_push, (w >= 0));
            chk("fifo_wdata", fifo_wdata, e_wd);
            chk("fifo_clr", fifo_clr, Reset);
            chk("out_valid", out_valid, e_valid);
            chk("fifo_pop", fifo_pop, e_pop);
            chk("out_last", out_last, e_last);
            chk("busy", busy, m_busy);
            chk("burst_done", burst_done, m_done);
            chk("burst_cnt", burst_cnt, 64'(m_cnt % 65536));
            g_seen = gnt;
            if (Reset) begin
                m_ptr = 0; m_beats = 0; m_cnt = 0; m_busy = 0; m_done = 0;
                exp_q.delete();
            end else begin
                if (w >= 0) begin
                    exp_q.push_back(e_wd);
                    m_ptr = (w + 1) % N;
                end
                m_done = 0;
                if (!m_busy) begin
                    eff = (int'(cfg_burst) > DEPTH) ? DEPTH : int'(cfg_burst);
                    if (cfg_en && eff > 0 && int'(fifo_count) >= eff) begin
                        m_busy = 1; m_beats = eff;
                    end
                end else if (e_pop) begin
                    if (m_beats == 1) begin
                        m_busy = 0; m_done = 1; m_cnt++;
                    end
                    m_beats--;
                end
            end
        end
    end

    // Monitor: every word the DUT pops must be the oldest word written.
    always @(negedge clk) begin : monitor
        logic [DW-1:0] e;
        if (rst_n && fifo_pop === 1'b1) begin
            if (exp_q.size() == 0) chk("out_underflow", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e);
            end
        end
    end

    // One cycle of requester behaviour: a granted requester loads new data
    // and re-requests with probability prob; idle ones request with prob.
    task automatic step(input int prob);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (g_seen[i] || !req[i]) begin
                req[i] = ($urandom_range(0, 99) < prob);
                req_data[i*DW +: DW] = {$urandom, $urandom};
            end
        end
    endtask

    initial begin
        rst_n = 0; Reset = 0; req = '0; req_data = '0;
        cfg_en = 0; cfg_burst = '0; out_rdy = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // All requesters busy, no drain: rotation, then FIFO fills and grants stop.
        repeat (24) step(100);

        // Oversized burst clamps to DEPTH.
        cfg_en = 1; cfg_burst = 5'd20; out_rdy = 1;
        repeat (30) step(0);

        // Zero-length burst never starts.
        cfg_burst = 5'd0;
        repeat (20) step(100);

        // Clear, then 4-beat bursts with steady and toggling ready.
        Reset = 1; step(0); Reset = 0;
        req = '0;
        cfg_burst = 5'd4;
        repeat (20) step(60);
        for (int c = 0; c < 40; c++) begin
            out_rdy = c[0];
            step(40);
        end

        // Reset two beats into a burst.
        out_rdy = 1; cfg_en = 0;
        Reset = 1; step(0); Reset = 0;
        repeat (6) step(100);
        req = '0;
        cfg_en = 1;
        for (int t = 0; t < 20 && !busy; t++) step(0);
        chk("burst_started", busy, 1);
        repeat (2) step(0);
        Reset = 1; step(0); Reset = 0;
        repeat (5) step(0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                cfg_burst = 5'($urandom_range(0, 20));
                cfg_en = ($urandom_range(0, 9) != 0);
            end
            out_rdy = ($urandom_range(0, 3) != 0);
            Reset = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 100));
        end
        Reset = 0;
        repeat (3) step(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
